// File: rtl/tlb_cam_array_if.sv
// Bus bundle for tlb_cam_array: lookup ports, indexed read/write, probe and
// Random/Wired control. clock/reset stay as plain ports on the CAM.
interface tlb_cam_array_if #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PORTS   = 2
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic                     Stall;
  logic [PORTS-1:0]         Lookup_Valid;
  logic [PORTS*20-1:0]      Lookup_VPN;
  logic [PORTS*8-1:0]       Lookup_ASID;
  logic [PORTS-1:0]         Hit;
  logic [PORTS*IDX_W-1:0]   Hit_Index;
  logic [PORTS-1:0]         Hit_Odd;

  logic                     Write;
  logic [IDX_W-1:0]         Write_Index;
  logic [43:0]              Write_Data;
  logic                     Invalidate_All;
  logic [IDX_W-1:0]         Read_Index;
  logic [43:0]              Read_Data;

  logic                     Probe;
  logic [18:0]              Probe_VPN2;
  logic [7:0]               Probe_ASID;
  logic                     Probe_Done;
  logic                     Probe_Miss;
  logic [IDX_W-1:0]         Probe_Index;

  logic                     Wired_Write;
  logic [IDX_W-1:0]         Wired_In;
  logic                     Random_Step;
  logic [IDX_W-1:0]         Wired;
  logic [IDX_W-1:0]         Random;
  logic                     Multi_Hit;

  modport master (
    output Stall, Lookup_Valid, Lookup_VPN, Lookup_ASID,
    output Write, Write_Index, Write_Data, Invalidate_All, Read_Index,
    output Probe, Probe_VPN2, Probe_ASID,
    output Wired_Write, Wired_In, Random_Step,
    input  Hit, Hit_Index, Hit_Odd, Read_Data,
    input  Probe_Done, Probe_Miss, Probe_Index, Wired, Random, Multi_Hit
  );

  modport slave (
    input  Stall, Lookup_Valid, Lookup_VPN, Lookup_ASID,
    input  Write, Write_Index, Write_Data, Invalidate_All, Read_Index,
    input  Probe, Probe_VPN2, Probe_ASID,
    input  Wired_Write, Wired_In, Random_Step,
    output Hit, Hit_Index, Hit_Odd, Read_Data,
    output Probe_Done, Probe_Miss, Probe_Index, Wired, Random, Multi_Hit
  );
endinterface

// File: rtl/tlb_cam_array.sv
// Fully-associative MIPS32 TLB tag CAM: PORTS registered lookups, indexed R/W,
// TLBP probe and CP0 Random/Wired. Optional macro: TLB_MULTIHIT_DETECT_EN.
module tlb_cam_array #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PORTS   = 2
) (
  input logic             clock,
  input logic             reset,
  tlb_cam_array_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  logic [ENTRIES-1:0]  r_valid;
  logic [18:0]         r_vpn2 [ENTRIES];
  logic [15:0]         r_mask [ENTRIES];
  logic [7:0]          r_asid [ENTRIES];
  logic [ENTRIES-1:0]  r_g;

  logic [PORTS-1:0]             r_hit;
  logic [PORTS-1:0][IDX_W-1:0]  r_hit_idx;
  logic [PORTS-1:0]             r_hit_odd;
  logic [43:0]                  r_read_data;
  logic                         r_probe_done;
  logic                         r_probe_miss;
  logic [IDX_W-1:0]             r_probe_idx;
  logic [IDX_W-1:0]             r_wired;
  logic [IDX_W-1:0]             r_random;

  logic [PORTS-1:0]             w_lk_any;
  logic [PORTS-1:0][IDX_W-1:0]  w_lk_idx;
  logic [PORTS-1:0]             w_lk_odd;
  logic                         w_pr_any;
  logic [IDX_W-1:0]             w_pr_idx;
  logic [18:0]                  w_wr_vpn2;

  function automatic logic f_match(input logic [19:0] vpn, input logic [7:0] asid,
                                   input logic v, input logic [18:0] vpn2,
                                   input logic [15:0] mask, input logic [7:0] easid,
                                   input logic g);
    return v && ({vpn[19:17], vpn[16:1] & ~mask} == vpn2) && ((asid == easid) || g);
  endfunction

  function automatic logic [4:0] f_popcnt(input logic [15:0] m);
    logic [4:0] n;
    n = '0;
    for (int unsigned b = 0; b < 16; b++) n = n + 5'(m[b]);
    return n;
  endfunction

`ifdef TLB_MULTIHIT_DETECT_EN
  logic [PORTS-1:0] w_lk_multi;
  logic             w_pr_multi;
  logic             r_multi;
`endif

  // Lowest-index match wins: only the first hit in ascending order is taken.
  always_comb begin
    w_lk_any = '0;
    w_lk_idx = '0;
    w_lk_odd = '0;
    w_pr_any = 1'b0;
    w_pr_idx = '0;
`ifdef TLB_MULTIHIT_DETECT_EN
    w_lk_multi = '0;
    w_pr_multi = 1'b0;
`endif
    for (int unsigned p = 0; p < PORTS; p++) begin
      for (int unsigned e = 0; e < ENTRIES; e++) begin
        if (f_match(bus.Lookup_VPN[p*20 +: 20], bus.Lookup_ASID[p*8 +: 8],
                    r_valid[e], r_vpn2[e], r_mask[e], r_asid[e], r_g[e])) begin
          if (!w_lk_any[p]) begin
            w_lk_any[p] = 1'b1;
            w_lk_idx[p] = IDX_W'(e);
            w_lk_odd[p] = bus.Lookup_VPN[p*20 + f_popcnt(r_mask[e])];
          end
`ifdef TLB_MULTIHIT_DETECT_EN
          else w_lk_multi[p] = 1'b1;
`endif
        end
      end
    end
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      if (f_match({bus.Probe_VPN2, 1'b0}, bus.Probe_ASID,
                  r_valid[e], r_vpn2[e], r_mask[e], r_asid[e], r_g[e])) begin
        if (!w_pr_any) begin
          w_pr_any = 1'b1;
          w_pr_idx = IDX_W'(e);
        end
`ifdef TLB_MULTIHIT_DETECT_EN
        else w_pr_multi = 1'b1;
`endif
      end
    end
  end

  assign w_wr_vpn2 = {bus.Write_Data[43:41], bus.Write_Data[40:25] & ~bus.Write_Data[24:9]};

  // Tag storage carries no reset; only the valid bits are cleared.
  always_ff @(posedge clock) begin
    if (bus.Write && !bus.Invalidate_All) begin
      r_vpn2[bus.Write_Index] <= w_wr_vpn2;
      r_mask[bus.Write_Index] <= bus.Write_Data[24:9];
      r_asid[bus.Write_Index] <= bus.Write_Data[8:1];
      r_g[bus.Write_Index]    <= bus.Write_Data[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid      <= '0;
      r_hit        <= '0;
      r_hit_idx    <= '0;
      r_hit_odd    <= '0;
      r_read_data  <= '0;
      r_probe_done <= 1'b0;
      r_probe_miss <= 1'b0;
      r_probe_idx  <= '0;
      r_wired      <= '0;
      r_random     <= LAST;
    end else begin
      if (bus.Invalidate_All) r_valid <= '0;
      else if (bus.Write)     r_valid[bus.Write_Index] <= 1'b1;

      if (!bus.Stall) begin
        for (int unsigned p = 0; p < PORTS; p++) begin
          r_hit[p]     <= bus.Lookup_Valid[p] && w_lk_any[p];
          r_hit_idx[p] <= (bus.Lookup_Valid[p] && w_lk_any[p]) ? w_lk_idx[p] : '0;
          r_hit_odd[p] <= bus.Lookup_Valid[p] && w_lk_any[p] && w_lk_odd[p];
        end
      end

      r_read_data <= {r_vpn2[bus.Read_Index], r_mask[bus.Read_Index],
                      r_asid[bus.Read_Index], r_g[bus.Read_Index]};

      r_probe_done <= bus.Probe;
      if (bus.Probe) begin
        r_probe_miss <= !w_pr_any;
        r_probe_idx  <= w_pr_idx;
      end

      // Wired load overrides a step; Random wraps from Wired back to the top.
      if (bus.Wired_Write) begin
        r_wired  <= bus.Wired_In;
        r_random <= LAST;
      end else if (bus.Random_Step && !bus.Stall) begin
        r_random <= (r_random <= r_wired) ? LAST : r_random - IDX_W'(1);
      end
    end
  end

`ifdef TLB_MULTIHIT_DETECT_EN
  always_ff @(posedge clock) begin
    if (reset)           r_multi <= 1'b0;
    else if (!bus.Stall) r_multi <= (|(bus.Lookup_Valid & w_lk_multi)) || (bus.Probe && w_pr_multi);
  end
  assign bus.Multi_Hit = r_multi;
`else
  assign bus.Multi_Hit = 1'b0;
`endif

  assign bus.Hit         = r_hit;
  assign bus.Hit_Index   = r_hit_idx;
  assign bus.Hit_Odd     = r_hit_odd;
  assign bus.Read_Data   = r_read_data;
  assign bus.Probe_Done  = r_probe_done;
  assign bus.Probe_Miss  = r_probe_miss;
  assign bus.Probe_Index = r_probe_idx;
  assign bus.Wired       = r_wired;
  assign bus.Random      = r_random;
endmodule

// File: tb/tb_tlb_cam_array.sv
// Self-checking bench for tlb_cam_array: directed table, corner sequences and
// random traffic against a behavioural TLB model. Honours TLB_MULTIHIT_DETECT_EN.
module tb_tlb_cam_array;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned PORTS   = 2;
  localparam int unsigned IDX_W   = 4;
`ifdef TLB_MULTIHIT_DETECT_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tlb_cam_array_if #(.ENTRIES(ENTRIES), .PORTS(PORTS)) bus ();
  tlb_cam_array #(.ENTRIES(ENTRIES), .PORTS(PORTS)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Model state: architectural TLB entries
  bit          m_valid   [ENTRIES];
  bit          m_written [ENTRIES];
  logic [18:0] m_vpn2    [ENTRIES];
  logic [15:0] m_mask    [ENTRIES];
  logic [7:0]  m_asid    [ENTRIES];
  bit          m_g       [ENTRIES];
  int          m_wired, m_random;

  // Expected outputs after the next edge
  logic [PORTS-1:0]       e_hit, e_odd;
  logic [IDX_W-1:0]       e_idx [PORTS];
  logic [43:0]            e_rd;
  bit                     e_rd_ok;
  logic                   e_pdone, e_pmiss, e_multi;
  logic [IDX_W-1:0]       e_pidx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_find(input logic [19:0] vpn, input logic [7:0] asid,
                                   output int first, output int n, output bit odd);
    first = -1; n = 0; odd = 1'b0;
    for (int e = 0; e < int'(ENTRIES); e++) begin
      if (m_valid[e] && (((int'(vpn >> 1)) & ~int'(m_mask[e])) == int'(m_vpn2[e]))
          && (m_g[e] || asid == m_asid[e])) begin
        n++;
        if (first < 0) begin
          first = e;
          odd = ((vpn >> $countones(m_mask[e])) & 20'd1) != 20'd0;
        end
      end
    end
  endfunction

  task automatic model_edge();
    int first, n;
    bit odd, any_multi;
    if (reset) begin
      for (int e = 0; e < int'(ENTRIES); e++) begin m_valid[e] = 0; m_written[e] = 0; end
      e_hit = '0; e_odd = '0; e_idx[0] = '0; e_idx[1] = '0;
      e_rd_ok = 0; e_pdone = 0; e_pmiss = 0; e_pidx = '0; e_multi = 0;
      m_wired = 0; m_random = ENTRIES - 1;
      return;
    end
    any_multi = 0;
    if (!bus.Stall) begin
      for (int p = 0; p < int'(PORTS); p++) begin
        ref_find(bus.Lookup_VPN[p*20 +: 20], bus.Lookup_ASID[p*8 +: 8], first, n, odd);
        e_hit[p] = bus.Lookup_Valid[p] && first >= 0;
        e_idx[p] = e_hit[p] ? IDX_W'(first) : '0;
        e_odd[p] = e_hit[p] && odd;
        if (bus.Lookup_Valid[p] && n >= 2) any_multi = 1;
      end
    end
    e_rd_ok = m_written[bus.Read_Index];
    e_rd = {m_vpn2[bus.Read_Index], m_mask[bus.Read_Index], m_asid[bus.Read_Index], m_g[bus.Read_Index]};
    e_pdone = bus.Probe;
    if (bus.Probe) begin
      ref_find({bus.Probe_VPN2, 1'b0}, bus.Probe_ASID, first, n, odd);
      e_pmiss = first < 0;
      e_pidx = (first < 0) ? '0 : IDX_W'(first);
      if (n >= 2) any_multi = 1;
    end
    if (!bus.Stall) e_multi = MH && any_multi;
    if (bus.Wired_Write) begin
      m_wired = int'(bus.Wired_In);
      m_random = ENTRIES - 1;
    end else if (bus.Random_Step && !bus.Stall) begin
      m_random = (m_random == m_wired) ? ENTRIES - 1 : m_random - 1;
    end
    if (bus.Invalidate_All) begin
      for (int e = 0; e < int'(ENTRIES); e++) m_valid[e] = 0;
    end else if (bus.Write) begin
      m_valid[bus.Write_Index]   = 1;
      m_written[bus.Write_Index] = 1;
      m_vpn2[bus.Write_Index] = bus.Write_Data[43:25] & ~{3'b000, bus.Write_Data[24:9]};
      m_mask[bus.Write_Index] = bus.Write_Data[24:9];
      m_asid[bus.Write_Index] = bus.Write_Data[8:1];
      m_g[bus.Write_Index]    = bus.Write_Data[0];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    chk("hit", bus.Hit, e_hit);
    chk("hit_index", bus.Hit_Index, {e_idx[1], e_idx[0]});
    chk("hit_odd", bus.Hit_Odd, e_odd);
    chk("probe_done", bus.Probe_Done, e_pdone);
    chk("probe_miss", bus.Probe_Miss, e_pmiss);
    chk("probe_index", bus.Probe_Index, e_pidx);
    chk("wired", bus.Wired, m_wired);
    chk("random", bus.Random, m_random);
    chk("multi_hit", bus.Multi_Hit, e_multi);
    if (e_rd_ok) chk("read_data", bus.Read_Data, e_rd);
  endtask

  task automatic idle();
    bus.Stall = 0; bus.Lookup_Valid = '0; bus.Lookup_VPN = '0; bus.Lookup_ASID = '0;
    bus.Write = 0; bus.Write_Index = '0; bus.Write_Data = '0; bus.Invalidate_All = 0;
    bus.Read_Index = '0; bus.Probe = 0; bus.Probe_VPN2 = '0; bus.Probe_ASID = '0;
    bus.Wired_Write = 0; bus.Wired_In = '0; bus.Random_Step = 0;
  endtask

  task automatic lookup2(input logic [19:0] vpn, input logic [7:0] asid);
    bus.Lookup_Valid = 2'b11;
    bus.Lookup_VPN = {vpn, vpn};
    bus.Lookup_ASID = {asid, asid};
  endtask

  task automatic wr(input int idx, input logic [18:0] vpn2, input logic [15:0] mask,
                    input logic [7:0] asid, input bit g);
    bus.Write = 1; bus.Write_Index = IDX_W'(idx); bus.Write_Data = {vpn2, mask, asid, g};
  endtask

  typedef struct {
    logic [1:0]  lv;
    logic [19:0] vpn;
    logic [7:0]  asid;
    bit          hit;
    logic [3:0]  idx;
    bit          odd;
  } vec_t;
  vec_t vecs [9];

  initial begin
    vecs[0] = '{2'b11, 20'h12345, 8'h01, 1, 4'd3, 1};
    vecs[1] = '{2'b11, 20'h12344, 8'h01, 1, 4'd3, 0};
    vecs[2] = '{2'b11, 20'h12345, 8'h02, 0, 4'd0, 0};
    vecs[3] = '{2'b11, 20'h00024, 8'h7F, 1, 4'd5, 1};
    vecs[4] = '{2'b11, 20'h00020, 8'h7F, 1, 4'd5, 0};
    vecs[5] = '{2'b11, 20'h00026, 8'h7F, 1, 4'd5, 1};
    vecs[6] = '{2'b11, 20'h00028, 8'h7F, 0, 4'd0, 0};
    vecs[7] = '{2'b11, 20'h12347, 8'h01, 0, 4'd0, 0};
    vecs[8] = '{2'b01, 20'h12345, 8'h01, 1, 4'd3, 1};

    idle();
    reset = 1;
    step(); step();
    reset = 0;

    lookup2(20'h12345, 8'h01);
    step();
    chk("tp_reset_hit", bus.Hit, 2'b00);
    chk("tp_reset_random", bus.Random, 15);
    chk("tp_reset_wired", bus.Wired, 0);

    idle(); wr(3, 19'h091A2, 16'h0000, 8'h01, 0); step();
    idle(); wr(5, 19'h00010, 16'h0003, 8'h00, 1); bus.Read_Index = 4'd3; step();
    idle(); bus.Read_Index = 4'd5; step();
    chk("tp_read5", bus.Read_Data, {19'h00010, 16'h0003, 8'h00, 1'b1});

    for (int i = 0; i < 9; i++) begin
      idle();
      bus.Lookup_Valid = vecs[i].lv;
      bus.Lookup_VPN = {vecs[i].vpn, vecs[i].vpn};
      bus.Lookup_ASID = {vecs[i].asid, vecs[i].asid};
      step();
      chk("tbl_hit", bus.Hit, vecs[i].lv & {2{vecs[i].hit}});
      chk("tbl_idx", bus.Hit_Index, {(vecs[i].lv[1] ? vecs[i].idx : 4'd0), (vecs[i].lv[0] ? vecs[i].idx : 4'd0)});
      chk("tbl_odd", bus.Hit_Odd, vecs[i].lv & {2{vecs[i].odd}});
    end

    // Write and lookup in the same cycle: old contents seen
    idle(); wr(7, 19'h20000, 16'h0000, 8'h01, 0); lookup2(20'h40000, 8'h01); step();
    chk("tp_wr_same_cycle", bus.Hit, 2'b00);
    idle(); lookup2(20'h40000, 8'h01); step();
    chk("tp_wr_next_cycle", bus.Hit_Index, {4'd7, 4'd7});

    // Duplicate tags, probe, then invalidate racing a write
    idle(); wr(9, 19'h0ABCD, 16'h0000, 8'h33, 0); step();
    idle(); wr(2, 19'h0ABCD, 16'h0000, 8'h33, 0); step();
    idle(); bus.Probe = 1; bus.Probe_VPN2 = 19'h0ABCD; bus.Probe_ASID = 8'h33; step();
    chk("tp_probe_done", bus.Probe_Done, 1);
    chk("tp_probe_miss", bus.Probe_Miss, 0);
    chk("tp_probe_idx", bus.Probe_Index, 2);
    chk("tp_multi", bus.Multi_Hit, MH);
    idle(); step();
    chk("tp_probe_pulse", bus.Probe_Done, 0);
    idle(); bus.Invalidate_All = 1; wr(4, 19'h0ABCD, 16'h0000, 8'h33, 0); step();
    idle(); bus.Probe = 1; bus.Probe_VPN2 = 19'h0ABCD; bus.Probe_ASID = 8'h33; lookup2(20'h12345, 8'h01); step();
    chk("tp_inv_miss", bus.Probe_Miss, 1);
    chk("tp_inv_idx", bus.Probe_Index, 0);
    chk("tp_inv_lookup", bus.Hit, 2'b00);

    // Wired / Random
    idle(); bus.Wired_Write = 1; bus.Wired_In = 4'd13; bus.Random_Step = 1; step();
    chk("tp_wired", bus.Wired, 13);
    chk("tp_random_load", bus.Random, 15);
    begin
      int seq [5] = '{14, 13, 15, 14, 13};
      for (int i = 0; i < 5; i++) begin
        idle(); bus.Random_Step = 1; step();
        chk("tp_random_seq", bus.Random, seq[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      idle(); bus.Random_Step = 1; bus.Stall = 1; step();
      chk("tp_random_stall", bus.Random, 13);
    end

    // Stall holds lookup outputs
    idle(); wr(6, 19'h00100, 16'h0000, 8'h05, 0); step();
    idle(); lookup2(20'h00201, 8'h05); step();
    chk("tp_pre_stall", bus.Hit_Odd, 2'b11);
    for (int i = 0; i < 2; i++) begin
      idle(); lookup2(20'h00300, 8'h05); bus.Stall = 1; step();
      chk("tp_stall_hit", bus.Hit, 2'b11);
      chk("tp_stall_idx", bus.Hit_Index, {4'd6, 4'd6});
    end
    idle(); lookup2(20'h00300, 8'h05); step();
    chk("tp_unstall", bus.Hit, 2'b00);

    // Reset during a probe
    idle(); bus.Probe = 1; bus.Probe_VPN2 = 19'h00100; bus.Probe_ASID = 8'h05; reset = 1; step();
    chk("tp_reset_probe", bus.Probe_Done, 0);
    reset = 0;

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      int k;
      logic [15:0] mask;
      idle();
      reset = ($urandom_range(0, 299) == 0);
      bus.Stall = ($urandom_range(0, 7) == 0);
      bus.Lookup_Valid = 2'($urandom_range(0, 3));
      bus.Lookup_VPN = {20'($urandom_range(0, 40)), 20'($urandom_range(0, 40))};
      bus.Lookup_ASID = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        mask = (k == 0) ? 16'h0000 : (k == 1) ? 16'h0003 : 16'h000F;
        wr($urandom_range(0, 15), 19'($urandom_range(0, 20)), mask,
           8'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      end
      bus.Invalidate_All = ($urandom_range(0, 79) == 0);
      bus.Read_Index = 4'($urandom_range(0, 15));
      bus.Probe = ($urandom_range(0, 3) == 0);
      bus.Probe_VPN2 = 19'($urandom_range(0, 20));
      bus.Probe_ASID = 8'($urandom_range(0, 3));
      bus.Wired_Write = ($urandom_range(0, 39) == 0);
      bus.Wired_In = 4'($urandom_range(0, 15));
      bus.Random_Step = ($urandom_range(0, 1) == 0);
      step();
    end
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
